// File: rtl/cmd_seq_player.sv
// Script-driven command sequencer for the RemoteComm send/response handshake.
// Replays up to DEPTH loaded commands, checks each response and reports the first failure.
module cmd_seq_player #(
    parameter int                DEPTH   = 16,
    parameter int                CMD_W   = 16,
    parameter int                RESP_W  = 8,
    parameter logic [RESP_W-1:0] ACK_VAL = 8'hA5,
    parameter int                TMO_W   = 24,
    localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_en_i,
    input  logic [AW-1:0]     ld_addr_i,
    input  logic [CMD_W-1:0]  ld_cmd_i,
    input  logic [TMO_W-1:0]  ld_tmo_i,
    input  logic [AW:0]       num_cmds_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              stop_on_err_i,
    output logic              send_cmd_o,
    output logic [CMD_W-1:0]  cmd_o,
    input  logic              cmd_sent_i,
    input  logic              resp_rdy_i,
    input  logic [RESP_W-1:0] resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [AW:0]       err_cnt_o,
    output logic [AW-1:0]     err_idx_o,
    output logic [1:0]        err_code_o,
    output logic [2:0]        state_o
);
    // Handshake: send_cmd_o is a one-cycle request with cmd_o stable until the entry
    // finishes; cmd_sent_i and resp_rdy_i are one-cycle strobes from RemoteComm.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_SENT = 3'd2;
    localparam logic [2:0] S_WAIT_RESP = 3'd3;
    localparam logic [2:0] S_NEXT      = 3'd4;
    localparam logic [2:0] S_FIN       = 3'd5;

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_NACK  = 2'd1;
    localparam logic [1:0] E_TMO   = 2'd2;
    localparam logic [1:0] E_STRAY = 2'd3;

    logic [CMD_W-1:0] cmd_mem [DEPTH];
    logic [TMO_W-1:0] tmo_mem [DEPTH];

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      num_q, num_d;
    logic             soe_q, soe_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             pass_q, pass_d;
    logic [AW:0]      err_cnt_q, err_cnt_d;
    logic [AW-1:0]    err_idx_q, err_idx_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             send_q, busy_q, done_q;

    logic             active, addr_ok, ld_we, tmo_hit, last_entry, err, aborted;
    logic [1:0]       err_cause;
    logic [TMO_W-1:0] cur_tmo;

    generate
        if (DEPTH == (1 << AW)) begin : g_full_addr
            assign addr_ok = 1'b1;
        end else begin : g_part_addr
            assign addr_ok = (32'(ld_addr_i) < DEPTH);
        end
    endgenerate

    assign active = (state_q != S_IDLE) && (state_q != S_FIN);
    assign ld_we  = ld_en_i && !active && addr_ok;
    assign cur_tmo = tmo_mem[idx_q];

    always_ff @(posedge clk_i) begin
        if (ld_we) begin
            cmd_mem[ld_addr_i] <= ld_cmd_i;
            tmo_mem[ld_addr_i] <= ld_tmo_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        soe_d      = soe_q;
        tmo_cnt_d  = tmo_cnt_q;
        cmd_d      = cmd_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        err_idx_d  = err_idx_q;
        err_code_d = err_code_q;
        err        = 1'b0;
        err_cause  = E_NONE;
        aborted    = 1'b0;
        tmo_hit    = (cur_tmo != '0) && (tmo_cnt_q == cur_tmo - TMO_W'(1));
        last_entry = ({1'b0, idx_q} == num_q - (AW+1)'(1));

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    num_d      = num_cmds_i;
                    soe_d      = stop_on_err_i;
                    idx_d      = '0;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    err_idx_d  = '0;
                    err_code_d = E_NONE;
                    state_d    = (num_cmds_i == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_SENT;
            end
            S_WAIT_SENT: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // A response arriving with cmd_sent counts as this entry's response.
                if (cmd_sent_i && resp_rdy_i) begin
                    if (resp_i == ACK_VAL) state_d = S_NEXT;
                    else begin err = 1'b1; err_cause = E_NACK; end
                end else if (cmd_sent_i) begin
                    state_d = S_WAIT_RESP;
                end else if (resp_rdy_i) begin
                    err = 1'b1; err_cause = E_STRAY;
                end else if (tmo_hit) begin
                    err = 1'b1; err_cause = E_TMO;
                end
            end
            S_WAIT_RESP: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (resp_rdy_i) begin
                    if (resp_i == ACK_VAL) state_d = S_NEXT;
                    else begin err = 1'b1; err_cause = E_NACK; end
                end else if (tmo_hit) begin
                    err = 1'b1; err_cause = E_TMO;
                end
            end
            S_NEXT: begin
                if (last_entry) state_d = S_FIN;
                else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (err) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + (AW+1)'(1);
            if (err_code_q == E_NONE) begin
                err_idx_d  = idx_q;
                err_code_d = err_cause;
            end
            state_d = soe_q ? S_FIN : S_NEXT;
        end

        // Abort overrides whatever this cycle's handshake would have recorded.
        if (abort_i && active) begin
            state_d    = S_FIN;
            aborted    = 1'b1;
            err_cnt_d  = err_cnt_q;
            err_idx_d  = err_idx_q;
            err_code_d = err_code_q;
        end

        if ((state_d == S_FIN) && (state_q != S_FIN)) pass_d = !aborted && (err_cnt_d == '0);
        // Bypass lets a write landing in the start cycle be played immediately.
        if (state_d == S_ISSUE) cmd_d = (ld_we && (ld_addr_i == idx_d)) ? ld_cmd_i : cmd_mem[idx_d];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            soe_q      <= 1'b0;
            tmo_cnt_q  <= '0;
            cmd_q      <= '0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_idx_q  <= '0;
            err_code_q <= E_NONE;
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            soe_q      <= soe_d;
            tmo_cnt_q  <= tmo_cnt_d;
            cmd_q      <= cmd_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_idx_q  <= err_idx_d;
            err_code_q <= err_code_d;
            send_q     <= (state_d == S_ISSUE);
            busy_q     <= (state_d != S_IDLE) && (state_d != S_FIN);
            done_q     <= (state_d == S_FIN);
        end
    end

    assign send_cmd_o = send_q;
    assign cmd_o      = cmd_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_cnt_q;
    assign err_idx_o  = err_idx_q;
    assign err_code_o = err_code_q;
    assign state_o    = state_q;
endmodule
